// File: rtl/psum_requant.sv
// Accumulates NUM_PASSES signed partial sums plus a per-output bias, then
// requantizes the total to int8 with a rounding shift, optional ReLU and saturation.
module psum_requant #(
   parameter int unsigned IN_WIDTH   = 21,
   parameter int unsigned NUM_PASSES = 4,
   parameter int unsigned ACC_WIDTH  = 32
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic signed [IN_WIDTH-1:0]  i_data,
   input  logic                        i_valid,
   input  logic signed [ACC_WIDTH-1:0] i_bias,
   input  logic [4:0]                  i_shift,
   input  logic                        i_relu_en,
   input  logic                        i_clear,
   output logic signed [7:0]           o_data,
   output logic                        o_valid
);

   localparam int unsigned CNT_W = (NUM_PASSES > 1) ? $clog2(NUM_PASSES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_PASSES - 1);
   localparam int unsigned RQ_W = ACC_WIDTH + 1;
   localparam logic signed [RQ_W-1:0] SAT_HI = RQ_W'(127);
   localparam logic signed [RQ_W-1:0] SAT_LO = ~SAT_HI;

   logic [CNT_W-1:0]           cnt;
   logic signed [ACC_WIDTH-1:0] acc;
   logic signed [ACC_WIDTH-1:0] sum_r;
   logic [4:0]                 shift_r;
   logic                       relu_r;
   logic                       s2_valid;

   logic signed [ACC_WIDTH-1:0] x_ext_c;
   logic signed [ACC_WIDTH-1:0] sum_next_c;
   logic                       first_beat_c;
   logic                       last_beat_c;

   logic signed [RQ_W-1:0]     rq_ext_c;
   logic signed [RQ_W-1:0]     rq_rnd_c;
   logic signed [RQ_W-1:0]     rq_shr_c;
   logic signed [RQ_W-1:0]     rq_relu_c;
   logic signed [7:0]          rq_sat_c;

   // First beat starts from the bias, later beats from the running sum
   assign x_ext_c      = {{(ACC_WIDTH-IN_WIDTH){i_data[IN_WIDTH-1]}}, i_data};
   assign first_beat_c = (cnt == '0);
   assign last_beat_c  = (cnt == CNT_LAST);
   assign sum_next_c   = (first_beat_c ? i_bias : acc) + x_ext_c;

   // Stage 1: pass counter, accumulator and hand-off of the finished group
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt      <= '0;
         acc      <= '0;
         sum_r    <= '0;
         shift_r  <= '0;
         relu_r   <= 1'b0;
         s2_valid <= 1'b0;
      end else begin
         s2_valid <= 1'b0;
         if (i_clear) begin
            cnt <= '0;
         end else if (i_valid) begin
            acc <= sum_next_c;
            if (last_beat_c) begin
               cnt      <= '0;
               sum_r    <= sum_next_c;
               shift_r  <= i_shift;
               relu_r   <= i_relu_en;
               s2_valid <= 1'b1;
            end else begin
               cnt <= cnt + CNT_W'(1);
            end
         end
      end
   end

   // Stage 2: round-half-up shift in one extra bit, then ReLU and int8 clamp
   always_comb begin
      rq_ext_c = {sum_r[ACC_WIDTH-1], sum_r};
      rq_rnd_c = '0;
      if (shift_r != 5'd0) begin
         rq_rnd_c = RQ_W'(1) << (shift_r - 5'd1);
      end
      rq_shr_c  = (rq_ext_c + rq_rnd_c) >>> shift_r;
      rq_relu_c = (relu_r && rq_shr_c[RQ_W-1]) ? '0 : rq_shr_c;
      if (rq_relu_c > SAT_HI) begin
         rq_sat_c = 8'h7F;
      end else if (rq_relu_c < SAT_LO) begin
         rq_sat_c = 8'h80;
      end else begin
         rq_sat_c = rq_relu_c[7:0];
      end
   end

   // Output register; data holds between strobes
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         o_data  <= '0;
         o_valid <= 1'b0;
      end else begin
         o_valid <= s2_valid;
         if (s2_valid) begin
            o_data <= rq_sat_c;
         end
      end
   end

endmodule

// File: tb/tb_psum_requant.sv
// Self-checking bench for psum_requant: directed vector table, gap/back-to-back,
// clear and reset sequences, and random groups against an arithmetic model.
module tb_psum_requant;

   logic               clk;
   logic               rst_n;
   logic signed [20:0] i_data;
   logic               i_valid;
   logic signed [31:0] i_bias;
   logic [4:0]         i_shift;
   logic               i_relu_en;
   logic               i_clear;
   logic signed [7:0]  o_data;
   logic               o_valid;

   psum_requant #(.IN_WIDTH(21), .NUM_PASSES(4), .ACC_WIDTH(32)) dut (
      .clk(clk), .rst_n(rst_n), .i_data(i_data), .i_valid(i_valid),
      .i_bias(i_bias), .i_shift(i_shift), .i_relu_en(i_relu_en),
      .i_clear(i_clear), .o_data(o_data), .o_valid(o_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic signed [31:0] bias;
      logic signed [20:0] d0, d1, d2, d3;
      logic [4:0]         sh;
      logic               relu;
      int                 exp;
   } vec_t;

   typedef struct {
      int val;
      int due;
   } exp_t;

   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;
   exp_t q[$];
   vec_t tbl[10];

   always @(posedge clk) cyc <= cyc + 1;

   // Output monitor: each expected result must appear at exactly its due cycle
   always @(negedge clk) begin
      if (q.size() > 0 && q[0].due == cyc) begin
         total++;
         if (!o_valid || int'(o_data) != q[0].val) begin
            bad++;
            $display("FAIL out@%0d: o_valid=%0b o_data=%0d required valid=1 data=%0d",
                     cyc, o_valid, o_data, q[0].val);
         end
         void'(q.pop_front());
      end else if (o_valid) begin
         total++;
         bad++;
         $display("FAIL spurious@%0d: o_valid=1 o_data=%0d required o_valid=0", cyc, o_data);
      end
   end

   // Reference: wrap the sum to 32 bits, then round/relu/clamp in wide arithmetic
   function automatic int model(input vec_t v);
      longint s;
      int     w;
      longint t;
      s = longint'(v.bias) + longint'(v.d0) + longint'(v.d1) + longint'(v.d2) + longint'(v.d3);
      w = int'(s);
      t = longint'(w);
      if (v.sh != 0) t = t + (longint'(1) <<< (int'(v.sh) - 1));
      t = t >>> int'(v.sh);
      if (v.relu && t < 0) t = 0;
      if (t > 127) t = 127;
      if (t < -128) t = -128;
      return int'(t);
   endfunction

   task automatic idle();
      i_valid   = 1'b0;
      i_data    = 21'($urandom);
      i_bias    = 32'($urandom);
      i_shift   = 5'($urandom);
      i_relu_en = 1'($urandom);
      @(posedge clk);
      #1;
   endtask

   task automatic beat(input logic signed [20:0] d, input logic signed [31:0] b,
                       input logic [4:0] sh, input logic rl, input logic clr);
      i_data    = d;
      i_bias    = b;
      i_shift   = sh;
      i_relu_en = rl;
      i_clear   = clr;
      i_valid   = 1'b1;
      @(posedge clk);
      #1;
      i_valid = 1'b0;
      i_clear = 1'b0;
   endtask

   // Bias only valid on beat 0, shift/relu only on beat 3; other beats carry noise
   task automatic send(input vec_t v, input int gap_max);
      logic signed [20:0] d[4];
      exp_t e;
      d[0] = v.d0; d[1] = v.d1; d[2] = v.d2; d[3] = v.d3;
      for (int k = 0; k < 4; k++) begin
         if (gap_max > 0) repeat ($urandom_range(0, gap_max)) idle();
         beat(d[k], (k == 0) ? v.bias : 32'($urandom),
              (k == 3) ? v.sh : 5'($urandom),
              (k == 3) ? v.relu : 1'($urandom), 1'b0);
      end
      e.val = v.exp;
      e.due = cyc + 1;
      q.push_back(e);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (q.size() > 0 && n < 50) begin
         idle();
         n++;
      end
      if (q.size() > 0) begin
         total++;
         bad++;
         $display("FAIL drain: %0d results still pending, required 0", q.size());
         q.delete();
      end
   endtask

   vec_t v;
   vec_t c;

   initial begin
      rst_n = 1'b0; i_valid = 1'b0; i_clear = 1'b0; i_data = '0;
      i_bias = '0; i_shift = '0; i_relu_en = 1'b0;

      tbl[0] = '{32'sd100,   21'sd10, 21'sd20, 21'sd30, 21'sd40, 5'd1,  1'b0, 100};
      tbl[1] = '{32'sd100,   21'sd10, 21'sd20, 21'sd30, 21'sd40, 5'd0,  1'b0, 127};
      tbl[2] = '{-32'sd1000, 21'sd0,  21'sd0,  21'sd0,  21'sd0,  5'd0,  1'b0, -128};
      tbl[3] = '{-32'sd1000, 21'sd0,  21'sd0,  21'sd0,  21'sd0,  5'd0,  1'b1, 0};
      tbl[4] = '{32'sd5,     21'sd0,  21'sd0,  21'sd0,  21'sd0,  5'd1,  1'b0, 3};
      tbl[5] = '{-32'sd5,    21'sd0,  21'sd0,  21'sd0,  21'sd0,  5'd1,  1'b0, -2};
      tbl[6] = '{32'sd0,     21'sd1,  21'sd2,  21'sd3,  21'sd0,  5'd2,  1'b0, 2};
      tbl[7] = '{32'sd100,   21'sd27, 21'sd0,  21'sd0,  21'sd0,  5'd31, 1'b0, 0};
      tbl[8] = '{32'sd0,     -21'sd7, 21'sd3,  21'sd0,  21'sd0,  5'd0,  1'b1, 0};
      tbl[9] = '{32'sd0,     -21'sd7, 21'sd3,  21'sd0,  21'sd0,  5'd0,  1'b0, -4};

      repeat (2) @(posedge clk);
      #1;
      total++;
      if (o_valid !== 1'b0 || o_data !== 8'sd0) begin
         bad++;
         $display("FAIL reset_state: o_valid=%0b o_data=%0d required 0/0", o_valid, o_data);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Directed table, gap-free
      for (int i = 0; i < 10; i++) send(tbl[i], 0);
      drain();

      // Same vectors with random idle cycles inside the group
      for (int i = 0; i < 10; i++) send(tbl[i], 3);
      drain();

      // Back-to-back groups: pulses exactly 4 cycles apart (due cycles enforce it)
      send(tbl[0], 0);
      send(tbl[4], 0);
      drain();

      // Clear with a simultaneous beat drops the partial group
      beat(21'sd7, 32'sd9, 5'd0, 1'b0, 1'b0);
      beat(21'sd11, 32'sd0, 5'd0, 1'b0, 1'b0);
      beat(21'sd50, 32'sd0, 5'd0, 1'b0, 1'b1);
      c = '{32'sd0, 21'sd1, 21'sd2, 21'sd3, 21'sd4, 5'd0, 1'b0, 10};
      send(c, 0);
      drain();

      // Asynchronous reset mid-group
      for (int k = 0; k < 3; k++) beat(21'sd5, 32'sd1, 5'd0, 1'b0, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      total++;
      if (o_valid !== 1'b0 || o_data !== 8'sd0) begin
         bad++;
         $display("FAIL async_reset: o_valid=%0b o_data=%0d required 0/0", o_valid, o_data);
      end
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      c = '{32'sd0, 21'sd8, 21'sd8, 21'sd8, 21'sd8, 5'd0, 1'b0, 32};
      send(c, 0);
      drain();

      // Random groups against the model
      for (int n = 0; n < 300; n++) begin
         v.bias = ($urandom_range(0, 3) == 0) ? 32'($urandom)
                                               : 32'($signed($urandom_range(0, 4000)) - 2000);
         if ($urandom_range(0, 1) == 0) begin
            v.d0 = 21'($urandom); v.d1 = 21'($urandom);
            v.d2 = 21'($urandom); v.d3 = 21'($urandom);
         end else begin
            v.d0 = 21'($signed($urandom_range(0, 600)) - 300);
            v.d1 = 21'($signed($urandom_range(0, 600)) - 300);
            v.d2 = 21'($signed($urandom_range(0, 600)) - 300);
            v.d3 = 21'($signed($urandom_range(0, 600)) - 300);
         end
         v.sh   = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 8));
         v.relu = 1'($urandom);
         v.exp  = model(v);
         send(v, ($urandom_range(0, 2) == 0) ? 2 : 0);
      end
      drain();
      repeat (5) idle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/psum_requant.md
# psum_requant

Downstream stage of the MAC array. Accumulates `NUM_PASSES` consecutive signed partial sums from one `macc` output into a single total and adds a per-output bias. It then applies a rounding arithmetic right shift, optional ReLU and saturation to int8. The int8 result feeds the activation write-back path and the next layer's 8-bit operand inputs.

## Interface
Parameters:
- `IN_WIDTH`, 21, width of signed partial sum from `macc` (16 + clog2(20)).
- `NUM_PASSES`, 4, partial sums per output value; legal range is 1 or more.
- `ACC_WIDTH`, 32, signed accumulator and bias width; must be greater than `IN_WIDTH`.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `i_data`  in  IN_WIDTH  signed partial sum; driven by `macc` `o_data`.
- `i_valid`  in  1  `i_data` valid; driven by `macc` `o_valid`.
- `i_bias`  in  ACC_WIDTH  signed bias; sampled on the first beat of a group.
- `i_shift`  in  5  right-shift amount, 0..31; sampled on the last beat.
- `i_relu_en`  in  1  ReLU enable; sampled on the last beat.
- `i_clear`  in  1  synchronous abort of the group in progress.
- `o_data`  out  8  signed int8 result.
- `o_valid`  out  1  one-cycle strobe; `o_data` is valid while it is high.

## Operation
- There is no backpressure. One beat is accepted on every cycle with `i_valid=1`. Full throughput is supported; groups may be back-to-back.
- Pass counter `cnt` runs 0..NUM_PASSES-1. It advances on each accepted beat and wraps to 0 after the last beat.
- Stage 1, accumulate:
  - Sign-extend `i_data` to `ACC_WIDTH`.
  - If `cnt==0`: `acc <= i_bias + x`.
  - Otherwise: `acc <= acc + x`.
  - On the last beat (`cnt==NUM_PASSES-1`), the final sum goes to `sum_r`:
    - `NUM_PASSES>1`: `sum_r <= acc + x`.
    - `NUM_PASSES==1`: `sum_r <= i_bias + x`.
  - On the last beat, `shift_r <= i_shift` and `relu_r <= i_relu_en`; `s2_valid` is set for one cycle.
- Arithmetic wraps modulo 2^ACC_WIDTH. There is no saturation inside the accumulator.
- Stage 2, requantize (registered to the output):
  - Rounding: `r = (sum_r + (shift_r ? 2^(shift_r-1) : 0)) >>> shift_r`, computed in ACC_WIDTH+1 bits so the rounding add cannot overflow. This is round-half-up toward +inf.
  - ReLU: if `relu_r` is set and `r < 0`, then `r = 0`.
  - Saturate: `r > 127` gives 127; `r < -128` gives -128.
  - Outputs: `o_data <= r[7:0]` and `o_valid <= s2_valid`.
- `o_data` holds its last value while `o_valid=0`.
- `i_clear`:
  - Forces `cnt <= 0`.
  - Discards the partial accumulation; `acc` is don't-care.
  - Has priority over a simultaneous `i_valid`; that beat is dropped.
  - Does not cancel a value already in `sum_r` or in the output register.
- Reset (`rst_n=0`, at any time):
  - `cnt`, `acc`, `sum_r`, `shift_r`, `relu_r`, `s2_valid`, `o_data` and `o_valid` all go to 0 immediately.
  - A group in progress is lost; the first beat after reset is treated as `cnt==0`.

## Timing
- Latency: last beat sampled at edge N, so `sum_r`/`s2_valid` are set at N and `o_data`/`o_valid` at N+1. That is 2 cycles from the last beat to the output.
- `o_valid` is high for exactly one cycle per completed group, never two groups in the same cycle.
- Minimum spacing between outputs is `NUM_PASSES` cycles.
- Idle cycles (`i_valid=0`) inside a group hold `cnt` and `acc` unchanged.
- Config sampling points:
  - Bias is taken only from the first beat; changes to `i_bias` on later beats have no effect.
  - Shift and ReLU are taken only from the last beat.

## Test plan
All scenarios use `NUM_PASSES=4`.
- Basic sum and shift: bias=100, data 10,20,30,40 back-to-back, shift=1, relu=0. Expect `o_valid` 2 cycles after the 4th beat and `o_data=100`.
- Saturation and ReLU:
  - Same group with shift=0: expect 127.
  - bias=-1000, data 0,0,0,0, relu=0: expect -128.
  - Same with relu=1: expect 0.
- Rounding:
  - Sum 5, shift=1: expect 3.
  - Sum -5, shift=1: expect -2.
  - Sum 6, shift=2: expect 2.
  - Sum 127, shift=31: expect 0.
- Gaps and back-to-back:
  - Beats with random idle cycles between them: output matches the gap-free result.
  - Two groups back-to-back: two single-cycle `o_valid` pulses exactly 4 cycles apart.
- Clear: after 2 beats, assert `i_clear` together with `i_valid` (data 50). Then send a fresh group with bias=0, data 1,2,3,4, shift=0. Expect exactly one output, value 10.
- Reset mid-group: assert `rst_n=0` asynchronously after 3 beats and check `o_valid=0`, `o_data=0` at once. Release, then send bias=0, data 4×8, shift=0: expect 32.
